usb_utmi_linestate_mon: RTL

// - Parametrised UTMI line-state monitor that sits between the UTMI PHY and the device core / SIE.
// - Debounces the 2-bit LineState and reports bus events: bus reset (SE0), suspend (idle J) and resume (K).
// - Timing is configurable per clock rate and filter depth, so it serves FS and HS PHY clocking.
//

---
 rtl/usb_utmi_pkg.sv | 30 +++
 rtl/usb_utmi_ls_filter.sv | 50 +++++
 rtl/usb_utmi_linestate_mon.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types and default 60 MHz line-state monitor timing.
package usb_utmi_pkg;

    typedef enum logic [1:0] {
        UTMI_LS_SE0 = 2'b00,
        UTMI_LS_DJ  = 2'b01,
        UTMI_LS_DK  = 2'b10,
        UTMI_LS_SE1 = 2'b11
    } utmi_line_state_t;

    typedef enum logic [1:0] {
        UTMI_OP_NORMAL         = 2'b00,
        UTMI_OP_NON_DRIVING    = 2'b01,
        UTMI_OP_DIS_STUFF_NRZI = 2'b10,
        UTMI_OP_RESERVED       = 2'b11
    } utmi_op_mode_t;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'b00,
        ST_RESET   = 2'b01,
        ST_SUSPEND = 2'b10,
        ST_RESUME  = 2'b11
    } usb_ls_mon_state_t;

    // 60 MHz defaults: 2.5 us of SE0 for bus reset, 3 ms of idle J for suspend.
    localparam int unsigned USB_LS_FILT_CYC_DEF    = 2;
    localparam int unsigned USB_LS_RESET_CYC_60M   = 150;
    localparam int unsigned USB_LS_SUSPEND_CYC_60M = 180000;

endpackage

// File: rtl/usb_utmi_ls_filter.sv
// LineState debounce: the raw value must be seen FILT_CYC times in a row
// (after one input register) before it is forwarded to ls_filt.
module usb_utmi_ls_filter
    import usb_utmi_pkg::*;
#(
    parameter int unsigned FILT_CYC = USB_LS_FILT_CYC_DEF  // 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] line_state,
    output logic [1:0] ls_filt
);

    localparam int unsigned STAB_W = 4;

    logic [1:0]        raw_q, raw_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [1:0]        ls_filt_q, ls_filt_d;

    // Count consecutive identical samples; forward the sample once stable.
    always_comb begin
        raw_d     = line_state;
        stab_d    = stab_q;
        ls_filt_d = ls_filt_q;
        if (line_state != raw_q) begin
            stab_d = STAB_W'(1);
        end else if (stab_q < STAB_W'(FILT_CYC)) begin
            stab_d = stab_q + STAB_W'(1);
        end
        if (stab_q >= STAB_W'(FILT_CYC)) begin
            ls_filt_d = raw_q;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q     <= 2'(UTMI_LS_DJ);
            stab_q    <= '0;
            ls_filt_q <= 2'(UTMI_LS_DJ);
        end else begin
            raw_q     <= raw_d;
            stab_q    <= stab_d;
            ls_filt_q <= ls_filt_d;
        end
    end

    assign ls_filt = ls_filt_q;

endmodule

// File: rtl/usb_utmi_linestate_mon.sv
// UTMI line-state monitor: debounced LineState, bus reset / suspend / resume
// detection. Optional sticky SE1 error flag under macro USB_LS_SE1_ERR_EN.
module usb_utmi_linestate_mon
    import usb_utmi_pkg::*;
#(
    parameter int unsigned FILT_CYC    = USB_LS_FILT_CYC_DEF,
    parameter int unsigned RESET_CYC   = USB_LS_RESET_CYC_60M,
    parameter int unsigned SUSPEND_CYC = USB_LS_SUSPEND_CYC_60M,
    parameter int unsigned CNT_W       = $clog2(SUSPEND_CYC + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] line_state,
    input  logic       tx_active,
    input  logic       rx_active,
    output logic [1:0] ls_filt,
    output logic [1:0] mon_state,
    output logic       bus_reset,
    output logic       bus_reset_start,
    output logic       suspend,
    output logic       resume
`ifdef USB_LS_SE1_ERR_EN
    ,
    output logic       se1_err
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] RESET_THR = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] SUSP_THR  = CNT_W'(SUSPEND_CYC - 1);

    utmi_line_state_t  ls_f;
    utmi_line_state_t  ls_last_q, ls_last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    usb_ls_mon_state_t state_q, state_d;
    logic              bus_reset_q, bus_reset_d;
    logic              bus_reset_start_q, bus_reset_start_d;
    logic              suspend_q, suspend_d;
    logic              resume_q, resume_d;
    logic              reset_hit, susp_hit;

    usb_utmi_ls_filter #(
        .FILT_CYC (FILT_CYC)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .line_state (line_state),
        .ls_filt    (ls_filt)
    );

    assign ls_f = utmi_line_state_t'(ls_filt);

    // Saturating event counter: cleared by line changes or our own transmit.
    always_comb begin
        ls_last_d = ls_f;
        cnt_d     = cnt_q;
        if ((ls_f != ls_last_q) || tx_active) begin
            cnt_d = '0;
        end else if ((ls_f == UTMI_LS_SE0) || ((ls_f == UTMI_LS_DJ) && !rx_active)) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Suspend also requires the bus to be quiet at the moment of detection.
    assign reset_hit = (ls_f == UTMI_LS_SE0) && (cnt_q == RESET_THR);
    assign susp_hit  = (ls_f == UTMI_LS_DJ) && (cnt_q == SUSP_THR) && !rx_active && !tx_active;

    // Next-state and registered-output logic; SE1 never moves the FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: begin
                if (reset_hit) begin
                    state_d = ST_RESET;
                end else if (susp_hit) begin
                    state_d = ST_SUSPEND;
                end
            end
            ST_RESET: begin
                if ((ls_f == UTMI_LS_DJ) || (ls_f == UTMI_LS_DK)) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_SUSPEND: begin
                if (tx_active) begin
                    state_d = ST_ACTIVE;
                end else if (ls_f == UTMI_LS_DK) begin
                    state_d = ST_RESUME;
                end else if (reset_hit) begin
                    state_d = ST_RESET;
                end
            end
            ST_RESUME: begin
                if ((ls_f == UTMI_LS_SE0) || (ls_f == UTMI_LS_DJ)) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase

        bus_reset_d       = (state_d == ST_RESET);
        bus_reset_start_d = (state_d == ST_RESET) && (state_q != ST_RESET);
        suspend_d         = (state_d == ST_SUSPEND);
        resume_d          = (state_q == ST_SUSPEND) && (state_d == ST_RESUME);
    end

    // Monitor state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ls_last_q         <= UTMI_LS_DJ;
            cnt_q             <= '0;
            state_q           <= ST_ACTIVE;
            bus_reset_q       <= 1'b0;
            bus_reset_start_q <= 1'b0;
            suspend_q         <= 1'b0;
            resume_q          <= 1'b0;
        end else begin
            ls_last_q         <= ls_last_d;
            cnt_q             <= cnt_d;
            state_q           <= state_d;
            bus_reset_q       <= bus_reset_d;
            bus_reset_start_q <= bus_reset_start_d;
            suspend_q         <= suspend_d;
            resume_q          <= resume_d;
        end
    end

    assign mon_state       = 2'(state_q);
    assign bus_reset       = bus_reset_q;
    assign bus_reset_start = bus_reset_start_q;
    assign suspend         = suspend_q;
    assign resume          = resume_q;

`ifdef USB_LS_SE1_ERR_EN
    logic se1_err_q, se1_err_d;

    // Sticky SE1 flag, cleared on bus reset entry.
    always_comb begin
        se1_err_d = se1_err_q || (ls_f == UTMI_LS_SE1);
        if ((state_d == ST_RESET) && (state_q != ST_RESET)) begin
            se1_err_d = 1'b0;
        end
    end

    // SE1 flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            se1_err_q <= 1'b0;
        end else begin
            se1_err_q <= se1_err_d;
        end
    end

    assign se1_err = se1_err_q;
`endif

endmodule
